read_8x8: RTL and testbench

- Reader counterpart of the 8x8 tile printer.
- The printer renders one byte as an 8x8 pixel tile in video memory: column c at x+c carries bit 7-c, lit for 1 and dark for 0.
- This block scans the same tile back through the video memory's read port and recovers the byte by a per-column majority vote.
- It sits beside the printer on the pixel-memory side and is used for loopback checking of the SERDES display path.

---
 rtl/read8x8_pkg.sv | 16 +
 rtl/column_vote.sv | 54 +++++
 rtl/read_8x8.sv | 156 +++++++++++++++
 tb/tb_read_8x8.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/read8x8_pkg.sv
// Shared constants and scan state type for the 8x8 tile reader.
// Widths match the tile printer so both blocks address the same memory.
package read8x8_pkg;

   localparam int unsigned TILE     = 8;
   localparam int unsigned LAST_IDX = 7;
   localparam int unsigned COL_W    = 3;
   localparam int unsigned SCAN_W   = 6;
   localparam int unsigned CNT_W    = 4;
   localparam int unsigned X_W      = 10;
   localparam int unsigned Y_W      = 9;
   localparam int unsigned COLOUR_W = 3;

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

endpackage

// File: rtl/column_vote.sv
// Eight per-column lit-pixel counters with clear and indexed increment.
// Vote and marginal outputs reflect the counts including this cycle's update.
module column_vote
   import read8x8_pkg::*;
#(
   parameter int unsigned VOTE_TH = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             inc,
   input  logic [COL_W-1:0] inc_idx,
   output logic [TILE-1:0]  bits_c,
   output logic             marg_c
);

   localparam logic [CNT_W-1:0] TH      = CNT_W'(VOTE_TH);
   localparam logic [CNT_W-1:0] MARG_LO = CNT_W'(3);
   localparam logic [CNT_W-1:0] MARG_HI = CNT_W'(2 * VOTE_TH - 5);

   logic [CNT_W-1:0] cnt_q [TILE];
   logic [CNT_W-1:0] cnt_d [TILE];

   // Column c maps to byte bit (LAST_IDX - c), matching the printer layout.
   always_comb begin
      bits_c = '0;
      marg_c = 1'b0;
      for (int i = 0; i < TILE; i++) begin
         cnt_d[i] = cnt_q[i];
         if (clear) begin
            cnt_d[i] = '0;
         end else if (inc && (inc_idx == COL_W'(i))) begin
            cnt_d[i] = cnt_q[i] + 1'b1;
         end
         bits_c[LAST_IDX - i] = (cnt_d[i] >= TH);
         if ((cnt_d[i] >= MARG_LO) && (cnt_d[i] <= MARG_HI)) begin
            marg_c = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < TILE; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < TILE; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

endmodule

// File: rtl/read_8x8.sv
// Scans an 8x8 tile from video memory column-major and recovers the byte
// by per-column majority vote; used for display-path loopback checking.
module read_8x8 #(
   parameter int unsigned X_W      = read8x8_pkg::X_W,
   parameter int unsigned Y_W      = read8x8_pkg::Y_W,
   parameter int unsigned COLOUR_W = read8x8_pkg::COLOUR_W,
   parameter int unsigned VOTE_TH  = 5
) (
   input  logic                CLOCK_50,
   input  logic                resetN,
   input  logic [X_W-1:0]      x,
   input  logic [Y_W-1:0]      y,
   input  logic                beginRead,
   output logic [X_W-1:0]      mem_x,
   output logic [Y_W-1:0]      mem_y,
   output logic                mem_rd,
   input  logic [COLOUR_W-1:0] mem_pixel,
   output logic [7:0]          dataOut,
   output logic                dataErr,
   output logic                doneRead,
   output logic                busy
);

   localparam int unsigned SCAN_W = read8x8_pkg::SCAN_W;
   localparam int unsigned COL_W  = read8x8_pkg::COL_W;
   localparam int unsigned TILE   = read8x8_pkg::TILE;
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(TILE * TILE - 1);

   read8x8_pkg::state_t state_q, state_d;

   logic              armed_q, armed_d;
   logic [X_W-1:0]    x_lat, x_lat_d;
   logic [Y_W-1:0]    y_lat, y_lat_d;
   logic [SCAN_W-1:0] idx_q, idx_d, nxt;
   logic [X_W-1:0]    mem_x_d;
   logic [Y_W-1:0]    mem_y_d;
   logic              mem_rd_d;
   logic [7:0]        data_d;
   logic              err_d, done_d, busy_d;
   logic              tag_valid_q;
   logic [COL_W-1:0]  tag_col_q;
   logic              clear_c, inc_c;
   logic [TILE-1:0]   vote_bits_c;
   logic              vote_marg_c;

   // Pixel data arrives one cycle after its read; the tag says which column.
   assign inc_c = tag_valid_q && (|mem_pixel);

   column_vote #(
      .VOTE_TH (VOTE_TH)
   ) u_vote (
      .clk     (CLOCK_50),
      .rst_n   (resetN),
      .clear   (clear_c),
      .inc     (inc_c),
      .inc_idx (tag_col_q),
      .bits_c  (vote_bits_c),
      .marg_c  (vote_marg_c)
   );

   // Next-state and next-output logic; outputs are registered below.
   always_comb begin
      state_d  = state_q;
      armed_d  = armed_q;
      x_lat_d  = x_lat;
      y_lat_d  = y_lat;
      idx_d    = idx_q;
      mem_x_d  = mem_x;
      mem_y_d  = mem_y;
      mem_rd_d = 1'b0;
      data_d   = dataOut;
      err_d    = dataErr;
      done_d   = 1'b0;
      busy_d   = busy;
      clear_c  = 1'b0;
      nxt      = idx_q + 1'b1;

      unique case (state_q)
         read8x8_pkg::IDLE: begin
            if (!beginRead) begin
               armed_d = 1'b1;
            end else if (armed_q) begin
               x_lat_d  = x;
               y_lat_d  = y;
               idx_d    = '0;
               mem_x_d  = x;
               mem_y_d  = y;
               mem_rd_d = 1'b1;
               busy_d   = 1'b1;
               armed_d  = 1'b0;
               clear_c  = 1'b1;
               state_d  = read8x8_pkg::READ;
            end
         end
         read8x8_pkg::READ: begin
            if (idx_q == SCAN_LAST) begin
               state_d = read8x8_pkg::DRAIN;
            end else begin
               idx_d    = nxt;
               mem_x_d  = x_lat + X_W'(nxt[SCAN_W-1:COL_W]);
               mem_y_d  = y_lat + Y_W'(nxt[COL_W-1:0]);
               mem_rd_d = 1'b1;
            end
         end
         read8x8_pkg::DRAIN: begin
            // Vote outputs already include the last pixel counted this cycle.
            data_d  = vote_bits_c;
            err_d   = vote_marg_c;
            done_d  = 1'b1;
            state_d = read8x8_pkg::DONE;
         end
         read8x8_pkg::DONE: begin
            busy_d  = 1'b0;
            state_d = read8x8_pkg::IDLE;
         end
         default: begin
            state_d = read8x8_pkg::IDLE;
         end
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge resetN) begin
      if (!resetN) begin
         state_q     <= read8x8_pkg::IDLE;
         armed_q     <= 1'b1;
         x_lat       <= '0;
         y_lat       <= '0;
         idx_q       <= '0;
         mem_x       <= '0;
         mem_y       <= '0;
         mem_rd      <= 1'b0;
         dataOut     <= '0;
         dataErr     <= 1'b0;
         doneRead    <= 1'b0;
         busy        <= 1'b0;
         tag_valid_q <= 1'b0;
         tag_col_q   <= '0;
      end else begin
         state_q     <= state_d;
         armed_q     <= armed_d;
         x_lat       <= x_lat_d;
         y_lat       <= y_lat_d;
         idx_q       <= idx_d;
         mem_x       <= mem_x_d;
         mem_y       <= mem_y_d;
         mem_rd      <= mem_rd_d;
         dataOut     <= data_d;
         dataErr     <= err_d;
         doneRead    <= done_d;
         busy        <= busy_d;
         tag_valid_q <= mem_rd;
         tag_col_q   <= idx_q[SCAN_W-1:COL_W];
      end
   end

endmodule

// File: tb/tb_read_8x8.sv
// Bench for read_8x8: video-memory model, transaction-level reference model
// compared every cycle, and directed scenarios with literal expectations.
module tb_read_8x8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [9:0] px;
   logic [8:0] py;
   logic       begin_r;
   logic [9:0] mem_x;
   logic [8:0] mem_y;
   logic       mem_rd;
   logic [2:0] mem_pixel = 3'b111;
   logic [7:0] dataOut;
   logic       dataErr;
   logic       doneRead;
   logic       busy;

   int errors = 0;
   int checks = 0;

   logic [2:0] vmem [0:1023][0:511];

   read_8x8 dut (
      .CLOCK_50  (clk),
      .resetN    (rst_n),
      .x         (px),
      .y         (py),
      .beginRead (begin_r),
      .mem_x     (mem_x),
      .mem_y     (mem_y),
      .mem_rd    (mem_rd),
      .mem_pixel (mem_pixel),
      .dataOut   (dataOut),
      .dataErr   (dataErr),
      .doneRead  (doneRead),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Memory: data one cycle after the read strobe, junk on idle cycles.
   always @(posedge clk) begin
      if (mem_rd) mem_pixel <= vmem[mem_x][mem_y];
      else        mem_pixel <= 3'b111;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic paint(input logic [7:0] b, input int xx, input int yy, input logic [2:0] colour);
      for (int c = 0; c < 8; c++)
         for (int r = 0; r < 8; r++)
            vmem[(xx + c) % 1024][(yy + r) % 512] = b[7 - c] ? colour : 3'b000;
   endtask

   // Majority vote straight from the memory contents.
   task automatic vote(input int xx, input int yy, output logic [7:0] b, output logic e);
      int n;
      b = 8'h00;
      e = 1'b0;
      for (int c = 0; c < 8; c++) begin
         n = 0;
         for (int r = 0; r < 8; r++)
            if (vmem[(xx + c) % 1024][(yy + r) % 512] != 3'b000) n++;
         b[7 - c] = (n >= 5);
         if (n >= 3 && n <= 5) e = 1'b1;
      end
   endtask

   // Reference model: start acceptance and result, tracked per edge.
   int         cyc = 0;
   int         m_start = 0;
   bit         m_active = 1'b0;
   bit         m_armed = 1'b1;
   int         m_x = 0;
   int         m_y = 0;
   logic [7:0] m_byte = 8'h00;
   logic       m_err = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active = 1'b0;
         m_armed  = 1'b1;
         m_byte   = 8'h00;
         m_err    = 1'b0;
      end else begin
         cyc++;
         if (m_active && cyc >= m_start + 67) m_active = 1'b0;
         if (m_active && cyc == m_start + 65) vote(m_x, m_y, m_byte, m_err);
         if (!m_active) begin
            if (!begin_r) begin
               m_armed = 1'b1;
            end else if (m_armed) begin
               m_armed  = 1'b0;
               m_active = 1'b1;
               m_start  = cyc;
               m_x      = int'(px);
               m_y      = int'(py);
            end
         end
      end
   end

   always @(negedge clk) begin
      int  k;
      bit  act;
      bit  exp_rd;
      act    = m_active && (rst_n === 1'b1);
      k      = cyc + 1 - m_start;
      exp_rd = act && k >= 1 && k <= 64;
      chk("mem_rd", int'(mem_rd), int'(exp_rd));
      chk("busy", int'(busy), int'(act && k >= 1 && k <= 66));
      chk("doneRead", int'(doneRead), int'(act && k == 66));
      chk("dataOut", int'(dataOut), int'(m_byte));
      chk("dataErr", int'(dataErr), int'(m_err));
      if (exp_rd) begin
         chk("mem_x", int'(mem_x), (m_x + (k - 1) / 8) % 1024);
         chk("mem_y", int'(mem_y), (m_y + (k - 1) % 8) % 512);
      end
   end

   task automatic scan(input int xx, input int yy, output int rd_cnt, output int done_at);
      rd_cnt  = 0;
      done_at = -1;
      @(negedge clk);
      px      = 10'(xx);
      py      = 9'(yy);
      begin_r = 1'b1;
      for (int j = 1; j <= 120 && done_at < 0; j++) begin
         @(negedge clk);
         begin_r = 1'b0;
         if (mem_rd) rd_cnt++;
         if (doneRead) done_at = j;
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int rd, dn, cnt;
      rst_n   = 1'b0;
      begin_r = 1'b0;
      px      = '0;
      py      = '0;
      repeat (3) @(negedge clk);
      chk("rst_mem_rd", int'(mem_rd), 0);
      chk("rst_dataOut", int'(dataOut), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_mem_x", int'(mem_x), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Clean tile 0xA5 at (16,8).
      paint(8'hA5, 16, 8, 3'b111);
      scan(16, 8, rd, dn);
      chk("a5_rd_count", rd, 64);
      chk("a5_done_at", dn, 66);
      chk("a5_byte", int'(dataOut), 8'hA5);
      chk("a5_err", int'(dataErr), 0);

      // Column 0 weak (3 lit), column 7 with 6 lit.
      for (int r = 3; r < 8; r++) vmem[16][8 + r] = 3'b000;
      for (int r = 0; r < 8; r++) vmem[23][8 + r] = (r < 6) ? 3'b001 : 3'b000;
      scan(16, 8, rd, dn);
      chk("marg_byte", int'(dataOut), 8'h25);
      chk("marg_err", int'(dataErr), 1);

      // Coordinates wrap at the edges of the address space.
      paint(8'h3C, 1020, 508, 3'b010);
      scan(1020, 508, rd, dn);
      chk("wrap_done_at", dn, 66);
      chk("wrap_byte", int'(dataOut), 8'h3C);
      chk("wrap_err", int'(dataErr), 0);

      // Held request triggers one scan; a low cycle re-arms.
      paint(8'hA5, 16, 8, 3'b111);
      @(negedge clk);
      px = 10'd16; py = 9'd8; begin_r = 1'b1;
      cnt = 0;
      repeat (200) begin
         @(negedge clk);
         if (doneRead) cnt++;
      end
      chk("held_done_count", cnt, 1);
      begin_r = 1'b0;
      @(negedge clk);
      begin_r = 1'b1;
      dn = -1;
      for (int j = 1; j <= 120 && dn < 0; j++) begin
         @(negedge clk);
         if (doneRead) dn = j;
      end
      chk("rearm_done_at", dn, 66);
      begin_r = 1'b0;
      repeat (3) @(negedge clk);

      // Reset in the middle of a scan.
      paint(8'h5A, 200, 100, 3'b100);
      @(negedge clk);
      px = 10'd200; py = 9'd100; begin_r = 1'b1;
      @(negedge clk);
      begin_r = 1'b0;
      repeat (29) @(negedge clk);
      chk("pre_rst_mem_rd", int'(mem_rd), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_mem_rd", int'(mem_rd), 0);
      chk("async_dataOut", int'(dataOut), 0);
      chk("async_busy", int'(busy), 0);
      cnt = 0;
      repeat (5) begin
         @(negedge clk);
         if (doneRead) cnt++;
      end
      chk("rst_no_done", cnt, 0);
      #2 rst_n = 1'b1;
      scan(200, 100, rd, dn);
      chk("post_rst_rd_count", rd, 64);
      chk("post_rst_done_at", dn, 66);
      chk("post_rst_byte", int'(dataOut), 8'h5A);

      // Request and x change while busy are ignored.
      @(negedge clk);
      px = 10'd16; py = 9'd8; begin_r = 1'b1;
      @(negedge clk);
      begin_r = 1'b0;
      repeat (19) @(negedge clk);
      px = 10'd500; begin_r = 1'b1;
      @(negedge clk);
      begin_r = 1'b0;
      cnt = 0;
      repeat (150) begin
         @(negedge clk);
         if (doneRead) cnt++;
      end
      chk("busy_done_count", cnt, 1);
      chk("busy_byte", int'(dataOut), 8'hA5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
